id_ex_stage: RTL and testbench

//  ID/EX pipeline register directly downstream of the opcode decoder (Controller).
//  - Captures the decoder's control bundle plus the ID-stage operands.
//  - Detects load-use hazards against the instruction in EX, stalls fetch/decode and injects a bubble.
//  - Accepts a flush from branch resolution in EX.

---
 rtl/id_ex_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection and flush.
// Optional perf counters (bubbles, flushed instructions) when ID_EX_PERF_EN is defined.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [7:0]        id_ctrl_i,
    input  logic [DATA_W-1:0] id_pc_i,
    input  logic [DATA_W-1:0] id_rd1_i,
    input  logic [DATA_W-1:0] id_rd2_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [3:0]        id_funct_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [7:0]        ex_ctrl_o,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic [DATA_W-1:0] ex_rd1_o,
    output logic [DATA_W-1:0] ex_rd2_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [REG_AW-1:0] ex_rs1_o,
    output logic [REG_AW-1:0] ex_rs2_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [3:0]        ex_funct_o
`ifdef ID_EX_PERF_EN
    ,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    localparam int unsigned MemReadBit = 4;

    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic              ex_valid_q, ex_valid_d;
    logic [7:0]        ex_ctrl_q, ex_ctrl_d;
    logic [DATA_W-1:0] ex_pc_q, ex_rd1_q, ex_rd2_q, ex_imm_q;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic [3:0]        ex_funct_q;

    logic rd_match;
    logic lu;
    logic load;

    assign rd_match = (ex_rd_q == id_rs1_i) || (ex_rd_q == id_rs2_i);
    assign lu       = ex_valid_q && ex_ctrl_q[MemReadBit] && id_valid_i
                      && (ex_rd_q != '0) && rd_match;
    assign stall_o  = rst_n && lu && !flush_i;
    assign load     = id_valid_i && !flush_i && !lu;

    // A bubble zeroes the whole control bundle so EX/MEM sees no side effects.
    always_comb begin
        ex_valid_d = load;
        ex_ctrl_d  = load ? id_ctrl_i : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= 8'h00;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    // Data fields only move on a real load; a bubble leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc_q    <= '0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            ex_funct_q <= '0;
        end else if (load) begin
            ex_pc_q    <= id_pc_i;
            ex_rd1_q   <= id_rd1_i;
            ex_rd2_q   <= id_rd2_i;
            ex_imm_q   <= id_imm_i;
            ex_rs1_q   <= id_rs1_i;
            ex_rs2_q   <= id_rs2_i;
            ex_rd_q    <= id_rd_i;
            ex_funct_q <= id_funct_i;
        end
    end

    assign ex_valid_o = ex_valid_q;
    assign ex_ctrl_o  = ex_ctrl_q;
    assign ex_pc_o    = ex_pc_q;
    assign ex_rd1_o   = ex_rd1_q;
    assign ex_rd2_o   = ex_rd2_q;
    assign ex_imm_o   = ex_imm_q;
    assign ex_rs1_o   = ex_rs1_q;
    assign ex_rs2_o   = ex_rs2_q;
    assign ex_rd_o    = ex_rd_q;
    assign ex_funct_o = ex_funct_q;

`ifdef ID_EX_PERF_EN
    logic             bubble_inc, flush_inc;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign bubble_inc = lu && !flush_i;
    assign flush_inc  = flush_i && id_valid_i;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bubble_inc && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
        if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the EX slot.
module tb_id_ex_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 2;
    localparam int          CntMax = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [7:0]        id_ctrl;
    logic [DATA_W-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic [3:0]        id_funct;
    logic              flush;
    logic              stall;
    logic              ex_valid;
    logic [7:0]        ex_ctrl;
    logic [DATA_W-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0]        ex_funct;
`ifdef ID_EX_PERF_EN
    logic [CNT_W-1:0]  bubble_cnt, flush_cnt;
`endif

    id_ex_stage #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid_i  (id_valid),
        .id_ctrl_i   (id_ctrl),
        .id_pc_i     (id_pc),
        .id_rd1_i    (id_rd1),
        .id_rd2_i    (id_rd2),
        .id_imm_i    (id_imm),
        .id_rs1_i    (id_rs1),
        .id_rs2_i    (id_rs2),
        .id_rd_i     (id_rd),
        .id_funct_i  (id_funct),
        .flush_i     (flush),
        .stall_o     (stall),
        .ex_valid_o  (ex_valid),
        .ex_ctrl_o   (ex_ctrl),
        .ex_pc_o     (ex_pc),
        .ex_rd1_o    (ex_rd1),
        .ex_rd2_o    (ex_rd2),
        .ex_imm_o    (ex_imm),
        .ex_rs1_o    (ex_rs1),
        .ex_rs2_o    (ex_rs2),
        .ex_rd_o     (ex_rd),
        .ex_funct_o  (ex_funct)
`ifdef ID_EX_PERF_EN
        ,
        .bubble_cnt_o(bubble_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model of what the EX slot should contain.
    typedef struct {
        logic              valid;
        logic [7:0]        ctrl;
        logic [DATA_W-1:0] pc, rd1, rd2, imm;
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic [3:0]        funct;
    } ex_slot_t;

    ex_slot_t m;
    int       m_bub;
    int       m_flu;

    task automatic model_reset();
        m = '{valid: 1'b0, ctrl: 8'h00, pc: '0, rd1: '0, rd2: '0, imm: '0,
              rs1: '0, rs2: '0, rd: '0, funct: '0};
        m_bub = 0;
        m_flu = 0;
    endtask

    // Is the instruction waiting in ID reading the register a load in EX is about to write?
    function automatic bit hazard();
        bit is_load = m.valid && (m.ctrl[4] == 1'b1);
        bit uses    = (m.rd == id_rs1) || (m.rd == id_rs2);
        return is_load && id_valid && (m.rd != 0) && uses;
    endfunction

    function automatic bit exp_stall();
        return hazard() && !flush;
    endfunction

    task automatic model_step();
        bit hz = hazard();
        if (flush) begin
            if (id_valid) m_flu = (m_flu < CntMax) ? m_flu + 1 : m_flu;
            m.valid = 1'b0;
            m.ctrl  = 8'h00;
        end else if (hz) begin
            m_bub   = (m_bub < CntMax) ? m_bub + 1 : m_bub;
            m.valid = 1'b0;
            m.ctrl  = 8'h00;
        end else if (!id_valid) begin
            m.valid = 1'b0;
            m.ctrl  = 8'h00;
        end else begin
            m = '{valid: 1'b1, ctrl: id_ctrl, pc: id_pc, rd1: id_rd1, rd2: id_rd2,
                  imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd, funct: id_funct};
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".valid"}, 64'(ex_valid), 64'(m.valid));
        check({tag, ".ctrl"},  64'(ex_ctrl),  64'(m.ctrl));
        check({tag, ".pc"},    64'(ex_pc),    64'(m.pc));
        check({tag, ".rd1"},   64'(ex_rd1),   64'(m.rd1));
        check({tag, ".rd2"},   64'(ex_rd2),   64'(m.rd2));
        check({tag, ".imm"},   64'(ex_imm),   64'(m.imm));
        check({tag, ".rs1"},   64'(ex_rs1),   64'(m.rs1));
        check({tag, ".rs2"},   64'(ex_rs2),   64'(m.rs2));
        check({tag, ".rd"},    64'(ex_rd),    64'(m.rd));
        check({tag, ".funct"}, 64'(ex_funct), 64'(m.funct));
`ifdef ID_EX_PERF_EN
        check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(m_bub));
        check({tag, ".flush_cnt"},  64'(flush_cnt),  64'(m_flu));
`endif
    endtask

    // Called just after a negedge with ID inputs already driven.
    task automatic cycle(input string tag);
        #1;
        check({tag, ".stall"}, 64'(stall), 64'(exp_stall()));
        model_step();
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [REG_AW-1:0] rs1,
                         input logic [REG_AW-1:0] rs2, input logic [REG_AW-1:0] rd,
                         input logic fl);
        id_valid = v;
        id_ctrl  = c;
        id_pc    = $urandom;
        id_rd1   = $urandom;
        id_rd2   = $urandom;
        id_imm   = $urandom;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        id_funct = 4'($urandom);
        flush    = fl;
    endtask

    localparam logic [7:0] CtrlLw  = 8'hF0;  // ALUSrc, MemToReg, RegWrite, MemRead
    localparam logic [7:0] CtrlAlu = 8'h22;  // RegWrite, ALUOp=01

    bit held;

    initial begin
        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, '0, '0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_state("reset");
        check("reset.stall", 64'(stall), 64'd0);
        rst_n = 1'b1;

        // T2 pass-through
        drive(1'b1, CtrlAlu, 5'd1, 5'd2, 5'd3, 1'b0);
        id_pc = 32'h40;
        cycle("t2");
        check("t2.ctrl_const", 64'(ex_ctrl), 64'h22);
        check("t2.pc_const", 64'(ex_pc), 64'h40);
        check("t2.valid_const", 64'(ex_valid), 64'd1);

        // T1 async reset mid-cycle with nonzero inputs and a load-use pending
        drive(1'b1, CtrlLw, 5'd1, 5'd2, 5'd5, 1'b0);
        cycle("t1a");
        drive(1'b1, CtrlAlu, 5'd5, 5'd5, 5'd7, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t1.valid", 64'(ex_valid), 64'd0);
        check("t1.ctrl", 64'(ex_ctrl), 64'd0);
        check("t1.pc", 64'(ex_pc), 64'd0);
        check("t1.rd", 64'(ex_rd), 64'd0);
        check("t1.stall", 64'(stall), 64'd0);
        @(negedge clk);
        check_state("t1b");
        rst_n = 1'b1;
        cycle("t1c");  // first cycle after release: empty EX, ID loads

        // T3 load-use on rs2
        drive(1'b1, CtrlLw, 5'd1, 5'd2, 5'd5, 1'b0);
        cycle("t3a");
        drive(1'b1, CtrlAlu, 5'd9, 5'd5, 5'd6, 1'b0);
        #1;
        check("t3.stall_const", 64'(stall), 64'd1);
        cycle("t3b");
        check("t3.bubble_valid", 64'(ex_valid), 64'd0);
        check("t3.bubble_ctrl", 64'(ex_ctrl), 64'd0);
        cycle("t3c");  // held instruction now enters EX
        check("t3.enter_rd", 64'(ex_rd), 64'd6);

        // T4 load to x0 never stalls
        drive(1'b1, CtrlLw, 5'd1, 5'd2, 5'd0, 1'b0);
        cycle("t4a");
        drive(1'b1, CtrlAlu, 5'd0, 5'd0, 5'd4, 1'b0);
        #1;
        check("t4.stall_const", 64'(stall), 64'd0);
        cycle("t4b");

        // T5 flush coincident with load-use
        drive(1'b1, CtrlLw, 5'd1, 5'd2, 5'd5, 1'b0);
        cycle("t5a");
        drive(1'b1, CtrlAlu, 5'd5, 5'd5, 5'd6, 1'b1);
        #1;
        check("t5.stall_const", 64'(stall), 64'd0);
        cycle("t5b");

        // T6 repeated load-use hazards drive the bubble counter into saturation
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, CtrlLw, 5'd1, 5'd2, 5'd5, 1'b0);
            cycle("t6a");
            drive(1'b1, CtrlAlu, 5'd5, 5'd1, 5'd6, 1'b0);
            cycle("t6b");
            cycle("t6c");
        end
`ifdef ID_EX_PERF_EN
        check("t6.bubble_sat", 64'(bubble_cnt), 64'd3);
`endif

        // Randomized traffic; ID is held while a stall is expected, as upstream would do.
        held = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (held) begin
                flush = ($urandom_range(0, 99) < 15);
            end else begin
                drive(($urandom_range(0, 99) < 80),
                      ($urandom_range(0, 1) != 0) ? (8'($urandom) | 8'h10)
                                                  : (8'($urandom) & 8'hEF),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 15));
            end
            held = exp_stall();
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
